// File: rtl/stack_mem_access_pkg.sv
// stack_mem_access_pkg
//   Shared definitions for the stack memory-access stage and its bound
//   checker: StackOp codes, fault codes, FSM state encoding and small
//   opcode-decode helpers.
package stack_mem_access_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } stack_op_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10,
    FLT_TMO  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_PUSH, OP_POP, OP_CALL, OP_RET: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_bound_check.sv
// stack_bound_check
//   Combinational stack range checker, shared with the SP stage.
//   Ports:
//     addr  in  DATA_W  stack address to check
//     we    in  1       1 = write access (PUSH/CALL), 0 = read (POP/RET)
//     fault out 2       FLT_NONE in range, FLT_OVF for an out-of-range write,
//                       FLT_UNF for an out-of-range read
module stack_bound_check
  import stack_mem_access_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STACK_TOP   = 1023,
  parameter int unsigned STACK_LIMIT = 0
) (
  input  logic [DATA_W-1:0] addr,
  input  logic              we,
  output fault_e            fault
);

  localparam logic [DATA_W-1:0] LIM  = DATA_W'(STACK_LIMIT);
  localparam logic [DATA_W-1:0] SPAN = DATA_W'(STACK_TOP - STACK_LIMIT);

  // Single unsigned compare on the offset from the bottom covers both ends:
  // addresses below STACK_LIMIT wrap to a large offset.
  logic [DATA_W-1:0] off;
  assign off = addr - LIM;

  always_comb begin
    fault = FLT_NONE;
    if (off > SPAN) begin
      if (we) fault = FLT_OVF;
      else    fault = FLT_UNF;
    end
  end

endmodule

// File: rtl/stack_mem_access.sv
// stack_mem_access
//   Memory-side stack stage: performs the single data-memory access needed
//   by PUSH, POP, CALL or RET over a req/ack handshake and returns the loaded
//   word (LMD). Out-of-range stack addresses fault without touching memory.
//   Optional feature macro: STACK_TIMEOUT_EN (ack watchdog, fault 11).
//   Ports:
//     clk, rst            clock (rising edge), async active-low reset
//     start, StackOp      one-cycle request and opcode
//     MemSP, rs_data, npc address, PUSH data, CALL return address
//     mem_req/we/addr/wdata, mem_ack, mem_rdata   data-memory handshake
//     LMD                 loaded word (POP data / RET target)
//     busy, done, fault   status: in progress, completion pulse, fault code
module stack_mem_access
  import stack_mem_access_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STACK_TOP   = 1023,
  parameter int unsigned STACK_LIMIT = 0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        StackOp,
  input  logic [DATA_W-1:0] MemSP,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] npc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] LMD,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fault
);

  state_e            state;
  fault_e            chk_flt;
  logic              op_wr;
  logic [DATA_W-1:0] op_wdata;

  assign op_wr    = op_is_write(StackOp);
  assign op_wdata = (StackOp == OP_CALL) ? npc : rs_data;

  stack_bound_check #(
    .DATA_W      (DATA_W),
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bound (
    .addr  (MemSP),
    .we    (op_wr),
    .fault (chk_flt)
  );

`ifdef STACK_TIMEOUT_EN
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      LMD       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= FLT_NONE;
`ifdef STACK_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && op_legal(StackOp)) begin
            mem_we    <= op_wr;
            mem_addr  <= MemSP;
            mem_wdata <= op_wdata;
            busy      <= 1'b1;
            fault     <= chk_flt;
            if (chk_flt == FLT_NONE) begin
              mem_req <= 1'b1;
              state   <= REQ;
`ifdef STACK_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            if (!mem_we) LMD <= mem_rdata;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
`ifdef STACK_TIMEOUT_EN
          // Ack on the final watchdog cycle still completes normally.
          else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            fault   <= FLT_TMO;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_access.sv
module tb_stack_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  StackOp;
  logic [31:0] MemSP, rs_data, npc, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata, LMD;
  logic [1:0]  fault;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stack_mem_access #(
    .DATA_W      (32),
    .STACK_TOP   (1023),
    .STACK_LIMIT (0),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .StackOp   (StackOp),
    .MemSP     (MemSP),
    .rs_data   (rs_data),
    .npc       (npc),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .LMD       (LMD),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  // Drives a one-cycle start; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] sp,
                       input logic [31:0] rsd, input logic [31:0] pc);
    @(negedge clk);
    start = 1'b1; StackOp = op; MemSP = sp; rs_data = rsd; npc = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; StackOp = 3'b000; MemSP = '0; rs_data = '0;
    npc = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    nvec++; if ({mem_req, mem_we, busy, done} !== 4'b0000) begin nerr++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, busy, done}); end
    nvec++; if ({mem_addr, mem_wdata, LMD} !== 96'h0) begin nerr++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, LMD}); end
    nvec++; if (fault !== 2'b00) begin nerr++; $display("FAIL reset_fault: got %b want 00", fault); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push;
    issue(3'b001, 32'd1022, 32'hDEADBEEF, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      nvec++; if ({mem_req, mem_we, busy, done} !== 4'b1110) begin nerr++; $display("FAIL push_ctrl c%0d: got %b want 1110", c, {mem_req, mem_we, busy, done}); end
      nvec++; if (mem_addr !== 32'd1022 || mem_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL push_bus c%0d: got %h/%h want 3fe/deadbeef", c, mem_addr, mem_wdata); end
      if (c == 3) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    nvec++; if ({mem_req, busy, done, fault} !== 5'b01100) begin nerr++; $display("FAIL push_done: got %b want 01100", {mem_req, busy, done, fault}); end
    nvec++; if (LMD !== 32'h0) begin nerr++; $display("FAIL push_lmd: got %h want 0", LMD); end
    @(negedge clk);
    nvec++; if ({busy, done} !== 2'b00) begin nerr++; $display("FAIL push_idle: got %b want 00", {busy, done}); end
  endtask

  task automatic test_pop;
    issue(3'b010, 32'd1022, 32'h0, 32'h0);
    nvec++; if ({mem_req, mem_we, done} !== 3'b100) begin nerr++; $display("FAIL pop_req: got %b want 100", {mem_req, mem_we, done}); end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'hFFFF0000;
    nvec++; if ({mem_req, done} !== 2'b01) begin nerr++; $display("FAIL pop_done_c2: got %b want 01", {mem_req, done}); end
    nvec++; if (LMD !== 32'h12345678) begin nerr++; $display("FAIL pop_lmd: got %h want 12345678", LMD); end
    @(negedge clk);
  endtask

  task automatic test_faults;
    issue(3'b001, 32'hFFFFFFFF, 32'h1, 32'h0);
    nvec++; if ({mem_req, busy, done, fault} !== 5'b01101) begin nerr++; $display("FAIL ovf_c1: got %b want 01101", {mem_req, busy, done, fault}); end
    @(negedge clk);
    nvec++; if ({busy, done, fault} !== 4'b0001) begin nerr++; $display("FAIL ovf_hold: got %b want 0001", {busy, done, fault}); end
    issue(3'b100, 32'd1024, 32'h0, 32'h0);
    nvec++; if ({mem_req, done, fault} !== 4'b0110) begin nerr++; $display("FAIL unf_c1: got %b want 0110", {mem_req, done, fault}); end
    nvec++; if (LMD !== 32'h12345678) begin nerr++; $display("FAIL unf_lmd: got %h want 12345678", LMD); end
    @(negedge clk);
    // Illegal opcode: ignored, fault holds.
    issue(3'b111, 32'd10, 32'h0, 32'h0);
    nvec++; if ({mem_req, busy, done, fault} !== 5'b00010) begin nerr++; $display("FAIL illegal_op: got %b want 00010", {mem_req, busy, done, fault}); end
    // Stray ack while idle: ignored.
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    nvec++; if (LMD !== 32'h12345678 || done !== 1'b0) begin nerr++; $display("FAIL idle_ack: got %h/%b want 12345678/0", LMD, done); end
  endtask

  task automatic test_call_ret;
    issue(3'b011, 32'd1022, 32'h99, 32'h40);
    nvec++; if ({mem_req, mem_we, fault} !== 4'b1100 || mem_wdata !== 32'h40 || mem_addr !== 32'd1022) begin nerr++; $display("FAIL call_req: got %b %h %h want 1100 40 3fe", {mem_req, mem_we, fault}, mem_wdata, mem_addr); end
    start = 1'b1; StackOp = 3'b010; MemSP = 32'd5;   // start while busy
    @(negedge clk);
    start = 1'b0;
    nvec++; if (mem_addr !== 32'd1022 || mem_we !== 1'b1 || mem_req !== 1'b1) begin nerr++; $display("FAIL busy_start: got %h %b %b want 3fe 1 1", mem_addr, mem_we, mem_req); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    nvec++; if ({done, mem_req} !== 2'b10 || LMD !== 32'h12345678) begin nerr++; $display("FAIL call_done: got %b %h want 10 12345678", {done, mem_req}, LMD); end
    @(negedge clk);
    nvec++; if ({busy, done, mem_req} !== 3'b000) begin nerr++; $display("FAIL call_after: got %b want 000", {busy, done, mem_req}); end
    issue(3'b100, 32'd1022, 32'h0, 32'h0);
    nvec++; if ({mem_req, mem_we} !== 2'b10) begin nerr++; $display("FAIL ret_req: got %b want 10", {mem_req, mem_we}); end
    mem_ack = 1'b1; mem_rdata = 32'h40;
    @(negedge clk);
    mem_ack = 1'b0;
    nvec++; if (done !== 1'b1 || LMD !== 32'h40) begin nerr++; $display("FAIL ret_lmd: got %b %h want 1 40", done, LMD); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(3'b010, 32'd1022, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++; if ({mem_req, busy, done} !== 3'b000 || LMD !== 32'h0 || mem_addr !== 32'h0) begin nerr++; $display("FAIL rst_mid: got %b %h %h want 000 0 0", {mem_req, busy, done}, LMD, mem_addr); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if ({mem_req, busy} !== 2'b00) begin nerr++; $display("FAIL rst_noresume: got %b want 00", {mem_req, busy}); end
    issue(3'b010, 32'd1023, 32'h0, 32'h0);
    nvec++; if (mem_req !== 1'b1 || fault !== 2'b00) begin nerr++; $display("FAIL top_bound: got %b %b want 1 00", mem_req, fault); end
    mem_ack = 1'b1; mem_rdata = 32'hA5A55A5A;
    @(negedge clk);
    mem_ack = 1'b0;
    nvec++; if (done !== 1'b1 || LMD !== 32'hA5A55A5A) begin nerr++; $display("FAIL rst_pop: got %b %h want 1 a5a55a5a", done, LMD); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    issue(3'b010, 32'd1000, 32'h0, 32'h0);
`ifdef STACK_TIMEOUT_EN
    repeat (15) @(negedge clk);
    nvec++; if (mem_req !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL tmo_c16: got %b %b want 1 0", mem_req, done); end
    @(negedge clk);
    nvec++; if ({mem_req, done, fault} !== 4'b0111 || LMD !== 32'hA5A55A5A) begin nerr++; $display("FAIL tmo_done: got %b %h want 0111 a5a55a5a", {mem_req, done, fault}, LMD); end
    @(negedge clk);
`else
    repeat (40) @(negedge clk);
    nvec++; if ({mem_req, busy, done, fault} !== 5'b11000) begin nerr++; $display("FAIL no_tmo_wait: got %b want 11000", {mem_req, busy, done, fault}); end
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    nvec++; if (done !== 1'b1 || LMD !== 32'h0BADF00D) begin nerr++; $display("FAIL no_tmo_done: got %b %h want 1 0badf00d", done, LMD); end
    @(negedge clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_push;
    test_pop;
    test_faults;
    test_call_ret;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stack_mem_access.md
Name: stack_mem_access

Overview:
- Memory-side stage directly downstream of the stack-pointer control stage.
- Takes the stack opcode and the computed memory stack address, then performs the single data-memory access that PUSH, POP, CALL or RET needs.
- Drives a req/ack handshake to data memory and returns the loaded word (LMD) to write-back or PC control.
- Checks stack bounds before touching memory; out-of-range accesses raise a fault instead.

Parameters:
- DATA_W, 32, data and address width
- STACK_TOP, 1023, highest legal stack address (empty-stack SP value)
- STACK_LIMIT, 0, lowest legal stack address
- TIMEOUT_CYC, 16, ack watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; samples the inputs below
- StackOp  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET; other codes illegal
- MemSP  in  DATA_W  stack memory address from the SP stage
- rs_data  in  DATA_W  PUSH store data
- npc  in  DATA_W  CALL store data (return address)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (PUSH/CALL), 0 = read (POP/RET)
- mem_addr  out  DATA_W  access address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- LMD  out  DATA_W  loaded word (POP data or RET target)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- fault  out  2  00 none, 01 overflow, 10 underflow, 11 timeout

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including LMD, mem_addr, mem_wdata and fault. mem_req drops immediately, even mid-operation. No access is resumed after reset release.
- FSM states and transitions:
  - IDLE: busy=0. On start with a legal StackOp, latch addr=MemSP, we=(PUSH|CALL), wdata=(CALL ? npc : rs_data).
    - Address in [STACK_LIMIT, STACK_TOP]: go to REQ.
    - Otherwise: go to DONE with fault set. A write out of range gives 01 (overflow, includes wrap to 0xFFFFFFFF). A read out of range gives 10 (underflow, e.g. 1024).
    - Illegal StackOp with start: ignored, stay in IDLE, no done pulse.
  - REQ: mem_req=1; mem_we, mem_addr and mem_wdata stay stable. When mem_ack=1 is sampled, a read loads LMD<=mem_rdata, then go to DONE. mem_req deasserts in the cycle after ack is sampled.
  - DONE: done=1 for exactly one cycle; busy=0 in the next cycle; return to IDLE.
- busy=1 in REQ and DONE.
- start while busy: ignored.
- fault holds until the next accepted start, which clears it to 00.
- LMD is unchanged by writes and by faulted operations.
- mem_ack seen in IDLE or DONE: ignored.
- Latency: start at cycle 0, mem_req high from cycle 1. Ack sampled at cycle k (k>=1) gives done at cycle k+1. Zero-wait memory gives done at cycle 2. A fault gives done at cycle 1.
- Back-to-back operation: start is accepted in the same cycle that done is high? No: start is accepted only in IDLE, so the earliest next start is the cycle after done.

Optional Feature:
- Macro STACK_TIMEOUT_EN.
- Defined: a counter runs in REQ. If no ack arrives within TIMEOUT_CYC cycles, the block drops mem_req, goes to DONE with fault=11 and leaves LMD unchanged. The counter clears on entry to REQ.
- Undefined: no counter; REQ waits indefinitely; fault code 11 is never produced.

Decomposition:
- Shared package holds:
  - StackOp codes: OP_PUSH=3'b001, OP_POP=3'b010, OP_CALL=3'b011, OP_RET=3'b100.
  - Fault codes: FLT_NONE, FLT_OVF, FLT_UNF, FLT_TMO.
  - FSM state encoding: IDLE, REQ, DONE.
- One natural sub-module: stack_bound_check, a combinational range checker (addr, we -> fault code), reusable by the SP stage.

Test Plan:
- PUSH: rs_data=0xDEADBEEF, MemSP=1022, ack after 3 cycles -> mem_we=1, mem_addr=1022, mem_wdata=0xDEADBEEF held stable; done pulses 1 cycle after ack; fault=00.
- POP: MemSP=1022, mem_rdata=0x12345678 with zero-wait ack -> LMD=0x12345678, done at cycle 2.
- Overflow: PUSH with MemSP=0xFFFFFFFF -> no mem_req, done at cycle 1, fault=01. Underflow: RET with MemSP=1024 -> fault=10.
- CALL with npc=0x40 then RET returning mem_rdata=0x40 -> write of 0x40 to 1022, then LMD=0x40; a start issued while busy is ignored.
- Reset mid-REQ: drive rst=0 while waiting for ack -> mem_req, busy and done go 0 immediately; after release a new POP completes normally.
- With STACK_TIMEOUT_EN and TIMEOUT_CYC=16, ack never asserted -> mem_req drops, done with fault=11, LMD unchanged.
